sram_rw_port_ctrl: RTL and testbench

- Front-end controller for the 256x24 single-port, byte-segment-masked SRAM macro (6-bit mask granule, 4 segments).
- Takes independent valid/ready write and read request channels and arbitrates them onto the macro's single RW port.
- Tracks the macro's 1-cycle read latency and buffers read data in a small response queue with credit-based flow control, so downstream backpressure never loses data.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_rw_port_ctrl_if.sv | 28 ++
 rtl/sram_resp_fifo.sv | 58 +++++
 rtl/sram_rw_port_ctrl.sv | 104 ++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and grant encoding for the SRAM RW-port controller.
package sram_ctrl_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 24;
  localparam int MASK_W     = 4;
  localparam int RESP_DEPTH = 2;
  localparam int SEG_W      = DATA_W / MASK_W;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response channels between an upstream client and the SRAM controller.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = sram_ctrl_pkg::DATA_W,
  parameter int MASK_W = sram_ctrl_pkg::MASK_W
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready,
    input  wr_ready, rd_ready, resp_valid, resp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready,
    output wr_ready, rd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_resp_fifo.sv
// Small response FIFO; storage is unreset, only pointers and occupancy are.
module sram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign pop_valid = (count != '0);
  assign pop_en    = pop && pop_valid;
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit upstream guarantees this never fires; a hit means the credit logic is broken.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop_en));
  end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Arbitrates write/read channels onto a single-port SRAM; read data returns in order
// through a credit-guarded response FIFO.
module sram_rw_port_ctrl #(
  parameter int ADDR_W     = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W     = sram_ctrl_pkg::DATA_W,
  parameter int MASK_W     = sram_ctrl_pkg::MASK_W,
  parameter int RESP_DEPTH = sram_ctrl_pkg::RESP_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  sram_rw_port_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_en,
  output logic               mem_wmode,
  output logic [MASK_W-1:0]  mem_wmask,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);
  import sram_ctrl_pkg::*;

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  grant_e           gnt_c;
  grant_e           last_grant;
  logic             rd_vld_p1;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   outstanding;
  logic             credit_ok;
  logic             wr_req;
  logic             rd_req;

  // Assert asynchronously, release two edges later so no flop sees a runt deassert.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign outstanding = {1'b0, fifo_count} + (CNT_W+1)'(rd_vld_p1);
  assign credit_ok   = (outstanding < (CNT_W+1)'(RESP_DEPTH));
  assign wr_req      = bus.wr_valid && rst_n_int;
  assign rd_req      = bus.rd_valid && credit_ok && rst_n_int;

  always_comb begin
    gnt_c = GNT_NONE;
    if (wr_req && rd_req) gnt_c = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    else if (wr_req)      gnt_c = GNT_WR;
    else if (rd_req)      gnt_c = GNT_RD;
  end

  assign bus.wr_ready = (gnt_c == GNT_WR);
  assign bus.rd_ready = (gnt_c == GNT_RD);

  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    case (gnt_c)
      GNT_WR: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = bus.wr_addr;
        mem_wmask = bus.wr_mask;
        mem_wdata = bus.wr_data;
      end
      GNT_RD: begin
        mem_en   = 1'b1;
        mem_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  // p0 -> p1: macro samples the read address; rdata is valid during the following cycle.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      last_grant <= GNT_RD;
      rd_vld_p1  <= 1'b0;
    end else begin
      if (gnt_c != GNT_NONE) last_grant <= gnt_c;
      rd_vld_p1 <= (gnt_c == GNT_RD);
    end
  end

  // p1 -> queue: capture macro output into the response FIFO.
  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk       (clock),
    .rst_n     (rst_n_int),
    .push      (rd_vld_p1),
    .push_data (mem_rdata),
    .pop       (bus.resp_valid && bus.resp_ready),
    .pop_valid (bus.resp_valid),
    .pop_data  (bus.resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed and randomized checks of the SRAM controller against a transaction-level model.
module tb_sram_rw_port_ctrl;

  localparam int AW = 8;
  localparam int DW = 24;
  localparam int MW = 4;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_wmode;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  sram_rw_port_ctrl_if bus ();

  sram_rw_port_ctrl dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_wmode (mem_wmode),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the 256x24 macro: registered read, segment-masked write.
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int s = 0; s < MW; s++)
          if (mem_wmask[s]) sram[mem_addr][s*6 +: 6] <= mem_wdata[s*6 +: 6];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Transaction-level reference: contents, expected responses with earliest visible cycle.
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } resp_t;

  logic [DW-1:0] ref_mem [256];
  resp_t         exp_q [$];
  logic          last_wr;
  int            cyc;
  int            n_chk;
  int            n_pass;
  logic          act_wr;
  logic          act_rd;

  function automatic logic [DW-1:0] masked(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int s = 0; s < MW; s++) if (m[s]) r[s*6 +: 6] = nw[s*6 +: 6];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_wr = 1'b0;
  endtask

  task automatic cycle();
    logic          rq_w, rq_r, e_wr, e_rd, e_rv;
    logic [DW-1:0] e_data;
    @(negedge clk);
    rq_w = bus.wr_valid;
    rq_r = bus.rd_valid && (exp_q.size() < RD);
    if (rq_w && rq_r) begin
      e_wr = !last_wr;
      e_rd = last_wr;
    end else begin
      e_wr = rq_w;
      e_rd = rq_r;
    end
    chk("wr_ready", 32'(bus.wr_ready), 32'(e_wr));
    chk("rd_ready", 32'(bus.rd_ready), 32'(e_rd));
    chk("mem_en", 32'(mem_en), 32'(e_wr | e_rd));
    chk("mem_wmode", 32'(mem_wmode), 32'(e_wr));
    if (e_wr || e_rd) chk("mem_addr", 32'(mem_addr), 32'(e_wr ? bus.wr_addr : bus.rd_addr));
    chk("mem_wmask", 32'(mem_wmask), 32'(e_wr ? bus.wr_mask : 4'h0));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wr ? bus.wr_data : 24'h0));
    e_rv   = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    e_data = e_rv ? exp_q[0].data : '0;
    chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    chk("resp_data", 32'(bus.resp_data), 32'(e_data));
    act_wr = bus.wr_ready;
    act_rd = bus.rd_ready;
    if (e_rv && bus.resp_ready) void'(exp_q.pop_front());
    if (act_wr) begin
      ref_mem[bus.wr_addr] = masked(ref_mem[bus.wr_addr], bus.wr_data, bus.wr_mask);
      last_wr = 1'b1;
    end
    if (act_rd) begin
      exp_q.push_back('{data: ref_mem[bus.rd_addr], avail: cyc + 2});
      last_wr = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int k;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_mask  = m;
    k = 0;
    do begin cycle(); k++; end while (!act_wr && k < 20);
    if (!act_wr) chk("wr_timeout", 32'(act_wr), 32'd1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_req(input logic [AW-1:0] a);
    int k;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    k = 0;
    do begin cycle(); k++; end while (!act_rd && k < 20);
    if (!act_rd) chk("rd_timeout", 32'(act_rd), 32'd1);
    bus.rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4);
  endtask

  initial begin
    logic [AW-1:0] rd3 [3];
    logic [5:0]    seq;
    int            issued, k;
    n_chk = 0; n_pass = 0; cyc = 0;
    act_wr = 1'b0; act_rd = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    mem_rdata      = '0;
    bus.wr_valid   = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_valid   = 1'b0; bus.rd_addr = '0;
    bus.resp_ready = 1'b1;
    do_reset();

    // Full write then read-back.
    wr_req(8'h10, 24'hABCDEF, 4'hF);
    rd_req(8'h10);
    idle(3);

    // Segment mask: clear segments 0 and 2.
    wr_req(8'h20, 24'hFFFFFF, 4'hF);
    wr_req(8'h20, 24'h000000, 4'b0101);
    rd_req(8'h20);
    idle(3);
    chk("mask_sram", 32'(sram[8'h20]), 32'hFC0FC0);

    // Zero mask still takes the port but leaves contents unchanged.
    wr_req(8'h10, 24'h123456, 4'h0);
    rd_req(8'h10);
    idle(3);

    // Backpressure: credit limits outstanding reads to the queue depth.
    rd3[0] = 8'h10; rd3[1] = 8'h20; rd3[2] = 8'hFF;
    bus.resp_ready = 1'b0;
    issued = 0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = rd3[0];
    repeat (5) begin
      cycle();
      if (act_rd) begin
        issued++;
        if (issued < 3) bus.rd_addr = rd3[issued];
      end
    end
    chk("rd_blocked", 32'(issued), 32'd2);
    bus.resp_ready = 1'b1;
    k = 0;
    while (issued < 3 && k < 20) begin
      cycle();
      k++;
      if (act_rd) issued++;
    end
    chk("third_rd", 32'(issued), 32'd3);
    idle(4);

    // Reset with a read in flight: nothing must surface afterwards.
    bus.resp_ready = 1'b0;
    rd_req(8'hFF);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(5);
    rd_req(8'hFF);
    rd_req(8'h01);
    bus.resp_ready = 1'b1;
    idle(4);

    // Round-robin under continuous contention, write first after reset.
    do_reset();
    seq = '0;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h40; bus.wr_data = 24'h000001; bus.wr_mask = 4'hF;
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h40;
    for (int i = 0; i < 6; i++) begin
      cycle();
      seq = {seq[4:0], act_wr};
      if (act_wr) begin
        bus.wr_addr = bus.wr_addr + 8'd1;
        bus.wr_data = bus.wr_data + 24'h111111;
      end
      if (act_rd) bus.rd_addr = bus.rd_addr + 8'd1;
    end
    chk("alt_seq", 32'(seq), 32'b101010);
    idle(4);

    // Read then write of the same address on consecutive grants.
    wr_req(8'h30, 24'h111111, 4'hF);
    rd_req(8'h30);
    wr_req(8'h30, 24'h222222, 4'hF);
    rd_req(8'h30);
    idle(4);

    // Randomized traffic over a small address set to force collisions.
    for (int i = 0; i < 600; i++) begin
      if (!bus.wr_valid || act_wr) begin
        bus.wr_valid = ($urandom_range(0, 1) == 1);
        bus.wr_addr  = ($urandom_range(0, 1) == 1) ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom_range(0, 3));
        bus.wr_data  = 24'($urandom);
        bus.wr_mask  = 4'($urandom_range(0, 15));
      end
      if (!bus.rd_valid || act_rd) begin
        bus.rd_valid = ($urandom_range(0, 1) == 1);
        bus.rd_addr  = ($urandom_range(0, 1) == 1) ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom_range(0, 3));
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.resp_ready = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
